drac_l15_req_arbiter: RTL and testbench
=======================================

// Module: drac_l15_req_arbiter
// PURPOSE
//  Shares the single L1.5 request channel between the core's memory requesters (I$ miss, D$ miss, write-buffer,
//  uncached read, uncached write, AMO). Sits between the cache-side request ports and the L1.5 adapter's output.
//  Fixed priority with starvation promotion, one registered request in flight, per-port outstanding-response limits.
// PARAMETERS
//  NumPorts        6    number of requesters; port 0 highest fixed priority
//  ReqWidth        128  opaque request payload width (bits)
//  MaxOutstanding  2    per-port max issued requests awaiting an L1.5 return (>=1)
//  StarveTh        8    lost arbitrations before a waiting port is promoted (>=1)
// PORTS
//  clk_i             in   1                  clock
//  reset_l           in   1                  asynchronous active-low reset
//  req_valid_i       in   NumPorts           per-port request valid
//  req_ready_o       out  NumPorts           per-port accept (one-hot or zero)
//  req_data_i        in   NumPorts*ReqWidth  payloads, port p at [p*ReqWidth +: ReqWidth]
//  req_needs_rtrn_i  in   NumPorts           request expects an L1.5 return (consumes a credit)
//  l15_val_o         out  1                  request valid towards L1.5
//  l15_req_o         out  ReqWidth           registered payload
//  l15_portid_o      out  $clog2(NumPorts)   originating port of l15_req_o
//  l15_ack_i         in   1                  L1.5 header ack; completes the issue
//  rtrn_valid_i      in   1                  L1.5 return for a credited request
//  rtrn_portid_i     in   $clog2(NumPorts)   port that return belongs to
//  busy_o            out  1                  state==ISSUE
// BEHAVIOUR
//  Reset (async, reset_l=0): state IDLE; l15_val_o=0, l15_req_o=0, l15_portid_o=0, busy_o=0, req_ready_o=0;
//   all credit and starvation counters 0. Reset mid-ISSUE abandons the request; l15_val_o falls asynchronously.
//  FSM IDLE: eligible[p] = req_valid_i[p] & (cnt[p] < MaxOutstanding). Winner = lowest-index starved eligible
//   port (starve[p]==StarveTh); else lowest-index eligible port. req_ready_o = onehot(winner), combinational,
//   only in IDLE. On valid&ready: capture payload/portid/needs_rtrn -> ISSUE; l15_val_o=1 next cycle (1-cycle latency).
//  FSM ISSUE: l15_val_o=1, payload stable, req_ready_o=0. On l15_ack_i -> IDLE; l15_val_o=0 next cycle.
//   Back-to-back issues therefore have >=1 idle cycle between l15_val_o pulses (max 1 issue / 2 cycles).
//  l15_ack_i while IDLE is ignored; rtrn_valid_i for a port with cnt==0 is ignored (no underflow).
//  Credits: cnt[p] +1 on ack when issued port==p and needs_rtrn; -1 on rtrn_valid_i for p; both same cycle -> unchanged.
//   Width $clog2(MaxOutstanding+1); never exceeds MaxOutstanding (eligibility gate guarantees it).
//  Starvation: on each IDLE handshake, starve[p] +1 (saturating at StarveTh) for every p with req_valid_i[p]
//   that was not the winner; starve[winner] cleared; starve[p] cleared whenever req_valid_i[p]=0. A port blocked
//   only by credits does not age (eligible=0 -> no increment).
//  Requesters must hold req_valid_i and payload until ready; dropping valid before ready is legal (no grant kept).
// STRUCTURE
//  Shared package drac_l15_arb_pkg: req_portid_t, port-index constants (ICACHE=0, DCACHE=1, WBUF=2, UC_READ=3,
//   UC_WRITE=4, AMO=5), state enum arb_state_t {IDLE, ISSUE}.
//  One sub-module: drac_l15_arb_prio_select (combinational: eligible + starved vectors -> one-hot winner + index).
//  Top holds FSM, output register, credit and starvation counter arrays.
// TESTING
//  Ports 1,3 valid same cycle, credits free -> ready_o=6'b000010; l15_val_o=1 next cycle, portid=1; ack -> port 3 next.
//  Port 0 valid continuously, port 5 valid, StarveTh=8 -> port 5 granted on 9th arbitration, starve[5] then 0.
//  Port 2 issues 2 needs_rtrn requests (MaxOutstanding=2), no returns -> port 2 ready stays 0; 1 rtrn -> re-granted.
//  Ack and rtrn for same port same cycle with cnt=1 -> cnt stays 1; rtrn with cnt=0 -> cnt stays 0.
//  Hold l15_ack_i=0 for 20 cycles in ISSUE -> l15_val_o,l15_req_o,portid stable; all req_ready_o=0 throughout.
//  Assert reset_l=0 mid-ISSUE -> l15_val_o=0 immediately; after release first valid port granted from IDLE, counters 0.

Source files
------------

// File: rtl/drac_l15_arb_pkg.sv
// Shared types and constants for the L1.5 request arbiter.
// Port indices, the port-id type and the arbiter state encoding.
package drac_l15_arb_pkg;

  localparam int unsigned NUM_PORTS = 6;
  localparam int unsigned PORTID_W  = $clog2(NUM_PORTS);

  typedef logic [PORTID_W-1:0] req_portid_t;

  localparam req_portid_t ICACHE   = req_portid_t'(0);
  localparam req_portid_t DCACHE   = req_portid_t'(1);
  localparam req_portid_t WBUF     = req_portid_t'(2);
  localparam req_portid_t UC_READ  = req_portid_t'(3);
  localparam req_portid_t UC_WRITE = req_portid_t'(4);
  localparam req_portid_t AMO      = req_portid_t'(5);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/drac_l15_arb_prio_select.sv
// Fixed-priority winner select: starved eligible ports pre-empt plain eligible ports,
// lowest index wins within each class.
module drac_l15_arb_prio_select #(
  parameter int unsigned NumPorts = 6
) (
  input  logic [NumPorts-1:0]         eligible,
  input  logic [NumPorts-1:0]         starved,
  output logic [NumPorts-1:0]         grant,
  output logic [$clog2(NumPorts)-1:0] grant_idx,
  output logic                        grant_valid
);

  localparam int unsigned IdxW = $clog2(NumPorts);

  logic [NumPorts-1:0] pick;

  always_comb begin
    pick        = (|starved) ? starved : eligible;
    grant_valid = |pick;
    grant_idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if (pick[p]) grant_idx = IdxW'(p);
    end
    grant = grant_valid ? (NumPorts'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/drac_l15_req_arbiter.sv
// Shares the single L1.5 request channel between the core's memory requesters.
// One registered request in flight, per-port return credits and starvation promotion.
module drac_l15_req_arbiter
  import drac_l15_arb_pkg::*;
#(
  parameter int unsigned NumPorts       = NUM_PORTS,
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveTh       = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_l,
  input  logic [NumPorts-1:0]            req_valid_i,
  output logic [NumPorts-1:0]            req_ready_o,
  input  logic [NumPorts*ReqWidth-1:0]   req_data_i,
  input  logic [NumPorts-1:0]            req_needs_rtrn_i,
  output logic                           l15_val_o,
  output logic [ReqWidth-1:0]            l15_req_o,
  output logic [$clog2(NumPorts)-1:0]    l15_portid_o,
  input  logic                           l15_ack_i,
  input  logic                           rtrn_valid_i,
  input  logic [$clog2(NumPorts)-1:0]    rtrn_portid_i,
  output logic                           busy_o
);

  localparam int unsigned PidW = $clog2(NumPorts);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned StvW = $clog2(StarveTh + 1);

  arb_state_t state_q, state_d;

  logic [NumPorts-1:0][CntW-1:0] credit_cnt;
  logic [NumPorts-1:0][StvW-1:0] starve_cnt;
  logic                          needs_rtrn_q;

  logic [NumPorts-1:0] eligible, starved, grant;
  logic [NumPorts-1:0] cnt_inc, cnt_dec;
  logic [PidW-1:0]     grant_idx;
  logic                grant_valid;
  logic                issue_hs, issue_done;
  logic [ReqWidth-1:0] sel_data;

  always_comb begin
    eligible = '0;
    starved  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      eligible[p] = req_valid_i[p] & (credit_cnt[p] < CntW'(MaxOutstanding));
      starved[p]  = eligible[p] & (starve_cnt[p] == StvW'(StarveTh));
    end
  end

  drac_l15_arb_prio_select #(
    .NumPorts (NumPorts)
  ) u_prio_select (
    .eligible    (eligible),
    .starved     (starved),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign issue_hs   = (state_q == IDLE) & grant_valid & reset_l;
  assign issue_done = (state_q == ISSUE) & l15_ack_i;
  assign sel_data   = req_data_i[int'(grant_idx)*ReqWidth +: ReqWidth];

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        // Ready is held low while reset is asserted even though the state reads IDLE.
        req_ready_o = reset_l ? grant : '0;
        if (grant_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (l15_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // l15_val_o decodes the state flop directly so reset drops it without waiting for a clock.
  assign l15_val_o = (state_q == ISSUE);
  assign busy_o    = (state_q == ISSUE);

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      l15_req_o    <= '0;
      l15_portid_o <= '0;
      needs_rtrn_q <= 1'b0;
    end else if (issue_hs) begin
      l15_req_o    <= sel_data;
      l15_portid_o <= grant_idx;
      needs_rtrn_q <= req_needs_rtrn_i[grant_idx];
    end
  end

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int p = 0; p < NumPorts; p++) begin
      cnt_inc[p] = issue_done & needs_rtrn_q & (l15_portid_o == PidW'(p));
      cnt_dec[p] = rtrn_valid_i & (rtrn_portid_i == PidW'(p)) & (credit_cnt[p] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      credit_cnt <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (cnt_inc[p] && !cnt_dec[p])      credit_cnt[p] <= credit_cnt[p] + CntW'(1);
        else if (cnt_dec[p] && !cnt_inc[p]) credit_cnt[p] <= credit_cnt[p] - CntW'(1);
      end
    end
  end

  // Only eligible losers age; a port held off purely by credits keeps its count.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      starve_cnt <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (!req_valid_i[p]) begin
          starve_cnt[p] <= '0;
        end else if (issue_hs) begin
          if (grant[p])
            starve_cnt[p] <= '0;
          else if (eligible[p] && (starve_cnt[p] != StvW'(StarveTh)))
            starve_cnt[p] <= starve_cnt[p] + StvW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_drac_l15_req_arbiter.sv
// Directed self-checking bench for drac_l15_req_arbiter with hand-computed expectations.
module tb_drac_l15_req_arbiter;

  localparam int NP = 6;
  localparam int RW = 128;

  logic              clk_i = 1'b0;
  logic              reset_l;
  logic [NP-1:0]     req_valid_i;
  logic [NP-1:0]     req_ready_o;
  logic [NP*RW-1:0]  req_data_i;
  logic [NP-1:0]     req_needs_rtrn_i;
  logic              l15_val_o;
  logic [RW-1:0]     l15_req_o;
  logic [2:0]        l15_portid_o;
  logic              l15_ack_i;
  logic              rtrn_valid_i;
  logic [2:0]        rtrn_portid_i;
  logic              busy_o;

  int n_cmp = 0;
  int n_err = 0;

  drac_l15_req_arbiter dut (
    .clk_i            (clk_i),
    .reset_l          (reset_l),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_data_i       (req_data_i),
    .req_needs_rtrn_i (req_needs_rtrn_i),
    .l15_val_o        (l15_val_o),
    .l15_req_o        (l15_req_o),
    .l15_portid_o     (l15_portid_o),
    .l15_ack_i        (l15_ack_i),
    .rtrn_valid_i     (rtrn_valid_i),
    .rtrn_portid_i    (rtrn_portid_i),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_data(input int p, input logic [RW-1:0] v);
    req_data_i[p*RW +: RW] = v;
  endtask

  initial begin
    reset_l          = 1'b0;
    req_valid_i      = '0;
    req_data_i       = '0;
    req_needs_rtrn_i = '0;
    l15_ack_i        = 1'b0;
    rtrn_valid_i     = 1'b0;
    rtrn_portid_i    = '0;
    #1;
    chk("rst_val",    l15_val_o,    0);
    chk("rst_req",    l15_req_o,    0);
    chk("rst_portid", l15_portid_o, 0);
    chk("rst_busy",   busy_o,       0);
    chk("rst_ready",  req_ready_o,  0);
    tick();
    tick();
    reset_l = 1'b1;
    #1;

    // Ports 1 and 3 contend; port 1 wins, then port 3.
    set_data(1, 128'hA1A1_0000_0000_0000_0000_0000_0000_0001);
    set_data(3, 128'hA3A3_0000_0000_0000_0000_0000_0000_0003);
    req_valid_i = 6'b001010;
    #1;
    chk("t1_ready_p1", req_ready_o, 6'b000010);
    tick();
    req_valid_i = 6'b001000;
    chk("t1_val",      l15_val_o, 1);
    chk("t1_busy",     busy_o, 1);
    chk("t1_portid",   l15_portid_o, 1);
    chk("t1_req",      l15_req_o, 128'hA1A1_0000_0000_0000_0000_0000_0000_0001);
    chk("t1_rdy_iss",  req_ready_o, 0);
    l15_ack_i = 1'b1;
    tick();
    l15_ack_i = 1'b0;
    #1;
    chk("t1_val_drop", l15_val_o, 0);
    chk("t1_ready_p3", req_ready_o, 6'b001000);
    tick();
    chk("t1_portid3",  l15_portid_o, 3);
    chk("t1_req3",     l15_req_o, 128'hA3A3_0000_0000_0000_0000_0000_0000_0003);
    req_valid_i = '0;
    l15_ack_i = 1'b1;
    tick();
    l15_ack_i = 1'b0;

    // Port 0 hogs the channel; port 5 is promoted on the 9th arbitration.
    req_valid_i = 6'b100001;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_ready_p0", req_ready_o, 6'b000001);
      tick();
      chk("t2_portid0", l15_portid_o, 0);
      l15_ack_i = 1'b1;
      tick();
      l15_ack_i = 1'b0;
      #1;
    end
    chk("t2_starve5_th", dut.starve_cnt[5], 8);
    chk("t2_ready_p5",   req_ready_o, 6'b100000);
    tick();
    chk("t2_portid5",    l15_portid_o, 5);
    chk("t2_starve5_clr", dut.starve_cnt[5], 0);
    req_valid_i = '0;
    l15_ack_i = 1'b1;
    tick();
    l15_ack_i = 1'b0;

    // Port 2 exhausts its two credits, then a return re-enables it.
    req_valid_i      = 6'b000100;
    req_needs_rtrn_i = 6'b000100;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t3_ready_p2", req_ready_o, 6'b000100);
      tick();
      l15_ack_i = 1'b1;
      tick();
      l15_ack_i = 1'b0;
      #1;
    end
    chk("t3_cnt2_full", dut.credit_cnt[2], 2);
    chk("t3_blocked",   req_ready_o, 0);
    tick();
    tick();
    chk("t3_blocked2",  req_ready_o, 0);
    chk("t3_val_idle",  l15_val_o, 0);
    chk("t3_no_age",    dut.starve_cnt[2], 0);
    rtrn_valid_i  = 1'b1;
    rtrn_portid_i = 3'd2;
    tick();
    rtrn_valid_i  = 1'b0;
    #1;
    chk("t3_cnt2_one",  dut.credit_cnt[2], 1);
    chk("t3_regrant",   req_ready_o, 6'b000100);
    tick();
    chk("t3_portid2",   l15_portid_o, 2);

    // Ack and return for port 2 in the same cycle leave the count alone.
    req_valid_i   = '0;
    l15_ack_i     = 1'b1;
    rtrn_valid_i  = 1'b1;
    rtrn_portid_i = 3'd2;
    tick();
    l15_ack_i     = 1'b0;
    rtrn_valid_i  = 1'b0;
    chk("t4_cnt2_same", dut.credit_cnt[2], 1);
    rtrn_valid_i  = 1'b1;
    rtrn_portid_i = 3'd4;
    tick();
    rtrn_valid_i  = 1'b0;
    chk("t4_cnt4_zero", dut.credit_cnt[4], 0);
    l15_ack_i = 1'b1;
    tick();
    l15_ack_i = 1'b0;
    chk("t4_ack_idle_val",  l15_val_o, 0);
    chk("t4_ack_idle_busy", busy_o, 0);
    chk("t4_ack_idle_cnt",  dut.credit_cnt[2], 1);
    rtrn_valid_i  = 1'b1;
    rtrn_portid_i = 3'd2;
    tick();
    rtrn_valid_i  = 1'b0;
    chk("t4_cnt2_drain", dut.credit_cnt[2], 0);
    req_needs_rtrn_i = '0;

    // Long ack stall: output frozen, nothing else accepted.
    set_data(4, 128'hD4D4_0000_1111_2222_3333_4444_5555_6666);
    req_valid_i = 6'b010000;
    tick();
    set_data(4, 128'hEEEE_0000_0000_0000_0000_0000_0000_0000);
    req_valid_i = 6'b011010;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t5_val",    l15_val_o, 1);
      chk("t5_req",    l15_req_o, 128'hD4D4_0000_1111_2222_3333_4444_5555_6666);
      chk("t5_portid", l15_portid_o, 4);
      chk("t5_ready",  req_ready_o, 0);
    end
    req_valid_i = '0;
    l15_ack_i = 1'b1;
    tick();
    l15_ack_i = 1'b0;

    // Reset in the middle of an issue.
    req_valid_i      = 6'b000001;
    req_needs_rtrn_i = 6'b000001;
    tick();
    req_valid_i = '0;
    l15_ack_i   = 1'b1;
    tick();
    l15_ack_i   = 1'b0;
    chk("t6_cnt0_pre", dut.credit_cnt[0], 1);
    req_valid_i = 6'b000001;
    tick();
    chk("t6_val_pre",  l15_val_o, 1);
    #3;
    reset_l = 1'b0;
    #1;
    chk("t6_val_async",  l15_val_o, 0);
    chk("t6_busy_async", busy_o, 0);
    chk("t6_ready_rst",  req_ready_o, 0);
    chk("t6_req_rst",    l15_req_o, 0);
    chk("t6_cnt_rst",    dut.credit_cnt, 0);
    req_valid_i      = 6'b001100;
    req_needs_rtrn_i = '0;
    set_data(2, 128'h2222_0000_0000_0000_0000_0000_0000_0022);
    tick();
    reset_l = 1'b1;
    #1;
    chk("t6_ready_post", req_ready_o, 6'b000100);
    tick();
    chk("t6_portid_post", l15_portid_o, 2);
    chk("t6_req_post",    l15_req_o, 128'h2222_0000_0000_0000_0000_0000_0000_0022);
    req_valid_i = '0;
    l15_ack_i   = 1'b1;
    tick();
    l15_ack_i   = 1'b0;
    chk("t6_val_end", l15_val_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
